// File: rtl/pulse_sequencer.sv
`timescale 1ns/1ps
// Multi-channel pulse-sequence generator: NCH gate windows plus one attenuator window
// inside a repeating period, with a shadowed config set and a start/stop/shot-count run controller.
module pulse_sequencer #(
  parameter int NCH = 4,
  parameter int CW  = 32,
  parameter int AW  = 7,
  parameter int SW  = 16
) (
  input  logic              clk_pll,
  input  logic              reset,
  input  logic [CW-1:0]     period,
  input  logic [NCH*CW-1:0] ch_start,
  input  logic [NCH*CW-1:0] ch_stop,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH-1:0]    ch_pol,
  input  logic [CW-1:0]     att_start,
  input  logic [CW-1:0]     att_stop,
  input  logic [AW-1:0]     att_in,
  input  logic [AW-1:0]     att_out_lvl,
  input  logic [SW-1:0]     shots,
  input  logic              load,
  input  logic              start,
  input  logic              stop,
  output logic [NCH-1:0]    ch_out,
  output logic [AW-1:0]     att,
  output logic              sync,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     shot_cnt,
  output logic [1:0]        dbg_state
);

  // Control is strobe based: load/start/stop are single-cycle pulses sampled on the
  // rising edge with no back-pressure; done and sync are single-cycle pulses out.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_t;

  typedef struct packed {
    logic [CW-1:0]     period;
    logic [NCH*CW-1:0] ch_start;
    logic [NCH*CW-1:0] ch_stop;
    logic [NCH-1:0]    ch_en;
    logic [NCH-1:0]    ch_pol;
    logic [CW-1:0]     att_start;
    logic [CW-1:0]     att_stop;
    logic [AW-1:0]     att_in;
    logic [AW-1:0]     att_out_lvl;
    logic [SW-1:0]     shots;
  } cfg_t;

  cfg_t           w_cfg_in;
  cfg_t           r_shadow;
  cfg_t           r_active;
  logic           r_pend;
  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [SW-1:0]  r_shot_cnt;
  logic [NCH-1:0] r_ch_out;
  logic [AW-1:0]  r_att;
  logic           r_sync;
  logic           r_done;

  logic           w_at_end;
  logic           w_final;
  logic           w_run_start;
  logic           w_terminate;
  logic           w_active_run;
  logic [NCH-1:0] w_ch_win;
  logic           w_att_win;

  assign w_cfg_in = '{period: period, ch_start: ch_start, ch_stop: ch_stop,
                      ch_en: ch_en, ch_pol: ch_pol, att_start: att_start,
                      att_stop: att_stop, att_in: att_in,
                      att_out_lvl: att_out_lvl, shots: shots};

  assign w_at_end = (r_cnt == r_active.period);
  assign w_final  = (r_active.shots != '0) &&
                    (SW'(r_shot_cnt + 1'b1) == r_active.shots);

  always_comb begin
    w_state_nxt = r_state;
    w_run_start = 1'b0;
    w_terminate = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_run_start = 1'b1;
        end
      end
      S_RUN: begin
        if (w_at_end && (w_final || stop)) begin
          w_state_nxt = S_IDLE;
          w_terminate = 1'b1;
        end else if (!w_at_end && stop) begin
          w_state_nxt = S_LAST;
        end
      end
      S_LAST: begin
        if (w_at_end) begin
          w_state_nxt = S_IDLE;
          w_terminate = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  assign w_active_run = (r_state != S_IDLE);

  always_comb begin
    w_ch_win = '0;
    for (int i = 0; i < NCH; i++) begin
      w_ch_win[i] = r_active.ch_en[i] &&
                    (r_cnt >= r_active.ch_start[i*CW +: CW]) &&
                    (r_cnt <  r_active.ch_stop[i*CW +: CW]);
    end
  end

  assign w_att_win = (r_cnt >= r_active.att_start) && (r_cnt < r_active.att_stop);

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_shot_cnt <= '0;
    end else begin
      if (w_run_start) r_shot_cnt <= '0;
      else if (w_active_run && w_at_end) r_shot_cnt <= r_shot_cnt + 1'b1;
      if (!w_active_run || w_at_end) r_cnt <= '0;
      else                           r_cnt <= r_cnt + 1'b1;
    end
  end

  // A load arriving in the boundary cycle itself is kept pending for the following boundary.
  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pend   <= 1'b0;
    end else begin
      if (load) r_shadow <= w_cfg_in;
      if (!w_active_run) begin
        if (r_pend) r_active <= r_shadow;
        if (load && start) r_active <= w_cfg_in;
        r_pend <= load;
      end else if (w_at_end) begin
        if (r_pend) r_active <= r_shadow;
        r_pend <= load;
      end else if (load) begin
        r_pend <= 1'b1;
      end
    end
  end

  // The terminating cycle already shows idle levels rather than the c == period window.
  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      r_ch_out <= '0;
      r_att    <= '0;
      r_sync   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_terminate;
      if (w_active_run && !w_terminate) begin
        r_ch_out <= r_active.ch_pol ^ w_ch_win;
        r_att    <= w_att_win ? r_active.att_in : r_active.att_out_lvl;
        r_sync   <= (r_cnt == '0);
      end else begin
        r_ch_out <= r_active.ch_pol;
        r_att    <= r_active.att_out_lvl;
        r_sync   <= 1'b0;
      end
    end
  end

  assign ch_out    = r_ch_out;
  assign att       = r_att;
  assign sync      = r_sync;
  assign busy      = w_active_run;
  assign done      = r_done;
  assign shot_cnt  = r_shot_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pulse_sequencer.sv
`timescale 1ns/1ps
// Bench for pulse_sequencer: per-run expected output traces are generated frame by frame
// from the window rules and compared cycle by cycle against the DUT.
module tb_pulse_sequencer;

  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int AW  = 7;
  localparam int SW  = 16;
  localparam int W   = 3 + AW + NCH + SW;

  logic              clk_pll = 1'b0;
  logic              reset;
  logic [CW-1:0]     period;
  logic [NCH*CW-1:0] ch_start;
  logic [NCH*CW-1:0] ch_stop;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    ch_pol;
  logic [CW-1:0]     att_start;
  logic [CW-1:0]     att_stop;
  logic [AW-1:0]     att_in;
  logic [AW-1:0]     att_out_lvl;
  logic [SW-1:0]     shots;
  logic              load;
  logic              start;
  logic              stop;
  logic [NCH-1:0]    ch_out;
  logic [AW-1:0]     att;
  logic              sync;
  logic              busy;
  logic              done;
  logic [SW-1:0]     shot_cnt;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int period;
    int st[NCH];
    int sp[NCH];
    bit en[NCH];
    bit pol[NCH];
    int att_s;
    int att_e;
    int ain;
    int aout;
    int shots;
  } cfg_s;

  cfg_s m_prev;
  cfg_s m_last;
  logic [W-1:0] exp_q[$];

  pulse_sequencer #(.NCH(NCH), .CW(CW), .AW(AW), .SW(SW)) dut (
    .clk_pll(clk_pll), .reset(reset), .period(period), .ch_start(ch_start),
    .ch_stop(ch_stop), .ch_en(ch_en), .ch_pol(ch_pol), .att_start(att_start),
    .att_stop(att_stop), .att_in(att_in), .att_out_lvl(att_out_lvl),
    .shots(shots), .load(load), .start(start), .stop(stop), .ch_out(ch_out),
    .att(att), .sync(sync), .busy(busy), .done(done), .shot_cnt(shot_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_pll = ~clk_pll;

  // ---------------- reference model ----------------
  function automatic cfg_s zero_cfg();
    cfg_s c;
    c.period = 0; c.att_s = 0; c.att_e = 0; c.ain = 0; c.aout = 0; c.shots = 0;
    for (int i = 0; i < NCH; i++) begin
      c.st[i] = 0; c.sp[i] = 0; c.en[i] = 1'b0; c.pol[i] = 1'b0;
    end
    return c;
  endfunction

  function automatic cfg_s rand_cfg();
    cfg_s c;
    c.period = $urandom_range(2, 10);
    for (int i = 0; i < NCH; i++) begin
      c.st[i]  = $urandom_range(0, c.period + 2);
      c.sp[i]  = $urandom_range(0, c.period + 2);
      c.en[i]  = 1'($urandom_range(0, 1));
      c.pol[i] = 1'($urandom_range(0, 1));
    end
    c.att_s = $urandom_range(0, c.period + 1);
    c.att_e = $urandom_range(0, c.period + 1);
    c.ain   = $urandom_range(0, 127);
    c.aout  = $urandom_range(0, 127);
    c.shots = $urandom_range(1, 3);
    return c;
  endfunction

  function automatic cfg_s plan_cfg();
    cfg_s c;
    c = zero_cfg();
    c.period = 9;
    c.st[0] = 2; c.sp[0] = 5; c.en[0] = 1'b1; c.pol[0] = 1'b0;
    c.st[1] = 1; c.sp[1] = 7; c.en[1] = 1'b0; c.pol[1] = 1'b1;
    c.st[2] = 6; c.sp[2] = 6; c.en[2] = 1'b1; c.pol[2] = 1'b0;
    c.st[3] = 7; c.sp[3] = 12; c.en[3] = 1'b1; c.pol[3] = 1'b1;
    c.att_s = 0; c.att_e = 1; c.ain = 'h7F; c.aout = 'h10;
    c.shots = 3;
    return c;
  endfunction

  function automatic logic [NCH-1:0] pol_vec(input cfg_s c);
    logic [NCH-1:0] p;
    for (int i = 0; i < NCH; i++) p[i] = c.pol[i];
    return p;
  endfunction

  function automatic logic [NCH-1:0] gates_at(input cfg_s c, input int k);
    logic [NCH-1:0] g;
    for (int i = 0; i < NCH; i++)
      g[i] = c.pol[i] ^ (c.en[i] && (k >= c.st[i]) && (k < c.sp[i]));
    return g;
  endfunction

  function automatic int att_at(input cfg_s c, input int k);
    return ((k >= c.att_s) && (k < c.att_e)) ? c.ain : c.aout;
  endfunction

  function automatic logic [W-1:0] pack(input bit d, input bit b, input bit s, input int a,
                                        input logic [NCH-1:0] ch, input int shot);
    logic [W-1:0] v;
    v = {d, b, s, AW'(a), ch, SW'(shot)};
    return v;
  endfunction

  // Entry j shows the counter value of cycle j-1; entry 1 shows the previous idle levels.
  task automatic build_trace(input cfg_s a, input cfg_s b, input int sw_frame, input int nfr);
    cfg_s c;
    exp_q.delete();
    exp_q.push_back(pack(1'b0, 1'b1, 1'b0, m_prev.aout, pol_vec(m_prev), 0));
    c = a;
    for (int f = 0; f < nfr; f++) begin
      if (f < sw_frame) c = a;
      else              c = b;
      for (int k = 0; k <= c.period; k++) begin
        if (f == nfr - 1 && k == c.period) begin
          exp_q.push_back(pack(1'b1, 1'b0, 1'b0, c.aout, pol_vec(c), nfr));
          exp_q.push_back(pack(1'b0, 1'b0, 1'b0, c.aout, pol_vec(c), nfr));
        end else begin
          exp_q.push_back(pack(1'b0, 1'b1, (k == 0), att_at(c, k), gates_at(c, k),
                               f + ((k == c.period) ? 1 : 0)));
        end
      end
    end
    m_last = c;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_cfg(input cfg_s c);
    period = CW'(c.period);
    for (int i = 0; i < NCH; i++) begin
      ch_start[i*CW +: CW] = CW'(c.st[i]);
      ch_stop[i*CW +: CW]  = CW'(c.sp[i]);
      ch_en[i]             = c.en[i];
      ch_pol[i]            = c.pol[i];
    end
    att_start   = CW'(c.att_s);
    att_stop    = CW'(c.att_e);
    att_in      = AW'(c.ain);
    att_out_lvl = AW'(c.aout);
    shots       = SW'(c.shots);
  endtask

  task automatic preload(input cfg_s c);
    @(negedge clk_pll);
    apply_cfg(c);
    load = 1'b1;
    @(negedge clk_pll);
    load = 1'b0;
    repeat (2) @(negedge clk_pll);
    m_prev = c;
  endtask

  // Scoreboard loop: one comparison per cycle of the expected trace.
  task automatic run_trace(input string name, input bit same_load, input cfg_s a,
                           input cfg_s b, input int sw_frame, input int nfr,
                           input int stop_j, input int load_j, input int start_j,
                           input int abort_j);
    logic [W-1:0] got;
    logic [W-1:0] ev;
    int n;
    build_trace(a, b, sw_frame, nfr);
    n = exp_q.size();
    @(negedge clk_pll);
    apply_cfg(a);
    load  = same_load;
    start = 1'b1;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk_pll);
      load = 1'b0; start = 1'b0; stop = 1'b0;
      got = {done, busy, sync, att, ch_out, shot_cnt};
      ev  = exp_q.pop_front();
      total++;
      if (got !== ev) begin
        bad++;
        $display("FAIL %s cycle=%0d got=%h exp=%h", name, j, got, ev);
      end
      if (j == abort_j) begin
        exp_q.delete();
        return;
      end
      if (j == stop_j) stop = 1'b1;
      if (j == load_j) begin
        apply_cfg(b);
        load = 1'b1;
      end
      if (j == start_j) start = 1'b1;
    end
    m_prev = m_last;
  endtask

  task automatic check_idle(input string name, input cfg_s c);
    logic [W-1:0] got;
    logic [W-1:0] ev;
    got = {done, busy, sync, att, ch_out, shot_cnt};
    ev  = {1'b0, 1'b0, 1'b0, AW'(c.aout), pol_vec(c), shot_cnt};
    total++;
    if (got !== ev || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL %s got=%h st=%0d exp=%h st=0", name, got, dbg_state, ev);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] got;
    reset = 1'b1;
    apply_cfg(zero_cfg());
    load = 1'b0; start = 1'b0; stop = 1'b0;
    m_prev = zero_cfg();
    repeat (2) @(negedge clk_pll);
    got = {done, busy, sync, att, ch_out, shot_cnt};
    total++;
    if (got !== '0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL reset got=%h st=%0d exp=0", got, dbg_state);
    end
    reset = 1'b0;
    @(negedge clk_pll);
    check_idle("reset_release", zero_cfg());
  endtask

  task automatic test_plan();
    run_trace("plan", 1'b1, plan_cfg(), plan_cfg(), 99, 3, 0, 0, 5, 0);
  endtask

  task automatic test_idle_levels();
    cfg_s c;
    c = rand_cfg();
    @(negedge clk_pll);
    apply_cfg(c);
    load = 1'b1;
    @(negedge clk_pll);
    load = 1'b0;
    stop = 1'b1;
    @(negedge clk_pll);
    stop = 1'b0;
    @(negedge clk_pll);
    check_idle("idle_levels", c);
    m_prev = c;
  endtask

  task automatic test_stop();
    cfg_s c;
    c = plan_cfg();
    c.shots = 0;
    run_trace("stop_mid", 1'b1, c, c, 99, 2, 15, 0, 0, 0);
    c.period = 5; c.shots = 2;
    run_trace("stop_final", 1'b1, c, c, 99, 2, 12, 0, 0, 0);
  endtask

  task automatic test_midload();
    cfg_s a;
    cfg_s b;
    a = plan_cfg();
    b = a;
    b.sp[0] = 8;
    run_trace("midload", 1'b1, a, b, 1, 3, 0, 4, 0, 0);
    b.period = 6;
    b.sp[0]  = 5;
    run_trace("midload_period", 1'b1, a, b, 1, 3, 0, 7, 0, 0);
  endtask

  task automatic test_random();
    cfg_s c;
    for (int r = 0; r < 6; r++) begin
      c = rand_cfg();
      if (r % 2 == 1) begin
        preload(c);
        run_trace("rand_preload", 1'b0, c, c, 99, c.shots, 0, 0, 0, 0);
      end else begin
        run_trace("rand_same", 1'b1, c, c, 99, c.shots, 0, 0, 0, 0);
      end
    end
  endtask

  task automatic test_async_reset();
    cfg_s c;
    logic [W-1:0] got;
    c = plan_cfg();
    c.shots = 0;
    run_trace("pre_reset", 1'b1, c, c, 99, 3, 0, 0, 0, 16);
    #2 reset = 1'b1;
    #1;
    got = {done, busy, sync, att, ch_out, shot_cnt};
    total++;
    if (got !== '0 || dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL async_reset got=%h st=%0d exp=0", got, dbg_state);
    end
    @(negedge clk_pll);
    reset = 1'b0;
    m_prev = zero_cfg();
    repeat (3) @(negedge clk_pll);
    check_idle("post_reset_idle", zero_cfg());
    c = rand_cfg();
    run_trace("rerun", 1'b1, c, c, 99, c.shots, 0, 0, 0, 0);
  endtask

  // ---------------- main + report ----------------
  initial begin
    test_reset();
    test_plan();
    test_idle_levels();
    test_stop();
    test_midload();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Multi-channel, parametrised pulse-sequence generator running on the PLL clock. Successor to the single-channel fixed-format pulse block. It produces NCH independent gate channels and one attenuator word, each defined by a programmable window inside a repeating period. It adds shadowed configuration, a start/stop/shot-count run controller and status outputs, and sits between the host register file and the RF switch/attenuator pins.

## Interface
Parameters:
- NCH, 4, number of gate channels (1..16)
- CW, 32, period/edge counter width
- AW, 7, attenuator word width
- SW, 16, shot counter width

Ports:
- clk_pll  in  1  PLL clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- period  in  CW  last counter value of a period (period length = period+1 cycles)
- ch_start  in  NCH*CW  per-channel window start, channel i at [i*CW +: CW]
- ch_stop  in  NCH*CW  per-channel window stop (exclusive)
- ch_en  in  NCH  channel enable
- ch_pol  in  NCH  output inversion / idle level
- att_start, att_stop  in  CW each  attenuator window
- att_in, att_out_lvl  in  AW each  attenuator level inside / outside window
- shots  in  SW  periods per run; 0 = continuous
- load  in  1  one-cycle strobe: capture all config inputs into shadow set
- start  in  1  one-cycle strobe: begin run
- stop  in  1  one-cycle strobe: end run at next period boundary
- ch_out  out  NCH  registered gate outputs
- att  out  AW  registered attenuator word
- sync  out  1  one-cycle frame marker
- busy  out  1  high while running
- done  out  1  one-cycle pulse at run end
- shot_cnt  out  SW  completed periods in current/last run

## Operation
- Two config sets: shadow (written by load) and active (drives comparators). Both reset to all-zero.
- States: IDLE, RUN, LAST.
- IDLE: counter held 0; ch_out = ch_pol (active), att = att_out_lvl (active), sync 0. load copies shadow to active in the following cycle. start -> RUN, counter starts at 0, shot_cnt cleared.
- RUN: counter c increments each cycle; at c == period it wraps to 0, shot_cnt += 1, pending shadow (if load seen since last boundary) copied to active for the new period. If shots != 0 and shot_cnt+1 == shots at wrap, or stop pending -> IDLE with done pulse instead of wrapping.
- LAST: entered on stop strobe; identical to RUN but terminates at next c == period. stop in IDLE ignored.
- Channel i (registered): ch_out[i] = ch_pol[i] XOR (ch_en[i] AND ch_start[i] <= c < ch_stop[i]). stop <= start gives an empty window. Edges > period are simply never reached.
- att = att_in when att_start <= c < att_stop, else att_out_lvl.
- sync = 1 in the cycle after c == 0 of each period in RUN/LAST.
- All comparisons unsigned CW-bit; counter never exceeds period; no overflow possible.
- start while busy ignored. load and start in same IDLE cycle: new config captured first, first period uses it. stop and final-shot wrap in same cycle: single termination, one done pulse. period changed mid-run via load takes effect only at boundary.

## Timing
- Output latency: one cycle from counter value to ch_out/att/sync.
- start at cycle t -> busy=1 at t+1, c=0 at t+1, first sync and window outputs at t+2.
- Run end: done=1 and busy=0 in cycle after last c == period; outputs return to idle levels that same cycle.
- Reset (any time, incl. mid-run): immediately ch_out=0, att=0, sync=0, busy=0, done=0, shot_cnt=0, counter 0, state IDLE, both config sets zero.

## Test plan
- period=9, ch0 start=2 stop=5 en=1 pol=0, shots=3, load, start -> ch0 high 3 cycles per 10-cycle frame, 3 sync pulses, done once, shot_cnt=3, busy low after 30 cycles.
- ch1 pol=1 en=0 -> ch1 constant 1 idle and running; ch2 start=6 stop=6 -> never asserted.
- shots=0 running, stop at c=4 -> frame completes to c=period, then done, idle outputs.
- Mid-run load changing ch0 stop 5->8 at c=3 -> current frame keeps stop=5, next frame uses 8.
- att_start=0 att_stop=1, att_in=0x7F att_out_lvl=0x10 -> att=0x7F exactly one cycle per frame.
- Assert reset at c=5 of frame 2 -> all outputs 0 asynchronously; after release, start required to rerun, config reloaded.
